// File: rtl/regfile_clr.sv
// regfile_clr: DEPTH x WIDTH register file with one synchronous write port,
// two combinational read ports and a hardware clear engine that zeroes one
// register per cycle after reset or on a clr request.
// Optional macro RF_BYPASS_EN: write-through from wd3 to a read port whose
// address matches wa3 while a write is in progress (not busy).
//
// state | meaning
// CLEAR | sweeping regb[cnt] <= 0, one register per cycle; busy = 1
// IDLE  | normal operation; writes accepted, reads return stored data

module regfile_clr #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [WIDTH-1:0]  wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              busy,
  output logic              wr_drop
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam bit                Z0    = (ZERO_REG != 0);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [WIDTH-1:0]  regb [DEPTH];

  // Clear-sequencing FSM; busy and wr_drop are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      cnt     <= '0;
      busy    <= 1'b1;
      wr_drop <= 1'b0;
    end else begin
      // A write attempted while the sweep runs is rejected and flagged next cycle.
      wr_drop <= we3 & busy;
      case (state)
        CLEAR: begin
          if (clr) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage: sweep zeroes regb[cnt]; otherwise the write port updates regb[wa3].
  // No reset here so that contents are never altered asynchronously.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regb[cnt] <= '0;
    end else if (we3 && !(Z0 && wa3 == '0)) begin
      regb[wa3] <= wd3;
    end
  end

  // Read port 1: zero while busy or for hardwired r0, optional write-through.
  always_comb begin
    rd1 = '0;
    if (!busy && !(Z0 && ra1 == '0)) begin
      rd1 = regb[ra1];
`ifdef RF_BYPASS_EN
      if (we3 && ra1 == wa3) rd1 = wd3;
`endif
    end
  end

  // Read port 2: same rule as port 1.
  always_comb begin
    rd2 = '0;
    if (!busy && !(Z0 && ra2 == '0)) begin
      rd2 = regb[ra2];
`ifdef RF_BYPASS_EN
      if (we3 && ra2 == wa3) rd2 = wd3;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_clr.sv
// tb_regfile_clr: directed, table-driven bench for regfile_clr (defaults:
// WIDTH 8, ADDR_W 4, ZERO_REG 1). Honours RF_BYPASS_EN if defined.

module tb_regfile_clr;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       we3;
  logic [3:0] wa3;
  logic [7:0] wd3;
  logic [3:0] ra1;
  logic [3:0] ra2;
  logic [7:0] rd1;
  logic [7:0] rd2;
  logic       busy;
  logic       wr_drop;

  int checks = 0;
  int errors = 0;

  regfile_clr #(.WIDTH(8), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .busy(busy), .wr_drop(wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] a1;
    logic [3:0] a2;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       edrop;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy falls, bounded; returns 99 on timeout.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) n = 99;
  endtask

  int  n;
  int  nz;
  logic [7:0] e;

  initial begin
    vt[0] = '{1'b1, 4'd3,  8'hA5, 4'd1,  4'd0,  8'h00, 8'h00, 1'b0};
    vt[1] = '{1'b1, 4'd0,  8'h5A, 4'd3,  4'd0,  8'hA5, 8'h00, 1'b0};
    vt[2] = '{1'b0, 4'd0,  8'h00, 4'd3,  4'd0,  8'hA5, 8'h00, 1'b0};
    vt[3] = '{1'b1, 4'd1,  8'h11, 4'd3,  4'd2,  8'hA5, 8'h00, 1'b0};
    vt[4] = '{1'b1, 4'd2,  8'h22, 4'd1,  4'd3,  8'h11, 8'hA5, 1'b0};
    vt[5] = '{1'b0, 4'd0,  8'h00, 4'd2,  4'd1,  8'h22, 8'h11, 1'b0};
    vt[6] = '{1'b1, 4'd15, 8'hF0, 4'd14, 4'd13, 8'h00, 8'h00, 1'b0};
    vt[7] = '{1'b0, 4'd0,  8'h00, 4'd15, 4'd2,  8'hF0, 8'h22, 1'b0};

    reset = 1'b1; clr = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
    #1;
    chk("reset_busy", busy, 1);
    chk("reset_drop", wr_drop, 0);
    tick(); tick();
    ra1 = 4'd5;
    #1;
    chk("reset_rd1", rd1, 0);
    reset = 1'b0;
    count_busy(n);
    chk("init_clear_len", n, 16);

    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i); ra2 = 4'(15 - i);
      #1;
      chk("post_init_rd1", rd1, 0);
      chk("post_init_rd2", rd2, 0);
    end

    for (int i = 0; i < 8; i++) begin
      we3 = vt[i].we; wa3 = vt[i].wa; wd3 = vt[i].wd; ra1 = vt[i].a1; ra2 = vt[i].a2;
      #1;
      chk($sformatf("vec%0d_rd1", i), rd1, vt[i].e1);
      chk($sformatf("vec%0d_rd2", i), rd2, vt[i].e2);
      tick();
      chk($sformatf("vec%0d_drop", i), wr_drop, vt[i].edrop);
    end
    we3 = 1'b0;

    // Fill r1..r15 with 0x10+n and read back.
    for (int i = 1; i < 16; i++) begin
      we3 = 1'b1; wa3 = 4'(i); wd3 = 8'(8'h10 + i);
      tick();
    end
    we3 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i);
      e = (i == 0) ? 8'h00 : 8'(8'h10 + i);
      #1;
      chk("fill_rd1", rd1, e);
    end

    // Clear request: 16 busy cycles, reads zero during the sweep.
    ra1 = 4'd5; ra2 = 4'd15;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy", busy, 1);
    n = 0; nz = 0;
    while (busy && n < 40) begin
      if (rd1 != 0 || rd2 != 0) nz++;
      tick();
      n++;
    end
    chk("clr_len", n, 16);
    chk("clr_reads_zero", nz, 0);
    for (int i = 0; i < 16; i++) begin
      ra2 = 4'(i);
      #1;
      chk("after_clr_rd2", rd2, 0);
    end

    // Second clr at cycle 5 of a clear restarts the 16-cycle sweep.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    count_busy(n);
    chk("restart_len", n, 16);

    // Rejected writes during a sweep (after r7 has already been swept).
    we3 = 1'b1; wa3 = 4'd7; wd3 = 8'h77;
    tick();
    we3 = 1'b0; ra1 = 4'd7;
    #1;
    chk("r7_written", rd1, 8'h77);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    we3 = 1'b1; wa3 = 4'd7; wd3 = 8'hFF;
    tick();
    chk("drop_1", wr_drop, 1);
    tick();
    chk("drop_2", wr_drop, 1);
    we3 = 1'b0;
    tick();
    chk("drop_end", wr_drop, 0);
    count_busy(n);
    chk("drop_clear_done", n < 40, 1);
    #1;
    chk("r7_zero", rd1, 0);
    chk("idle_drop", wr_drop, 0);

    // clr and we3 together in IDLE: write happens, then swept to zero.
    we3 = 1'b1; wa3 = 4'd4; wd3 = 8'h44; clr = 1'b1;
    tick();
    we3 = 1'b0; clr = 1'b0;
    chk("clrwe_drop", wr_drop, 0);
    count_busy(n);
    chk("clrwe_len", n, 16);
    ra1 = 4'd4;
    #1;
    chk("clrwe_r4", rd1, 0);

    // Reset at cycle 8 of a sweep aborts it; full sweep after release.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    #1;
    chk("midreset_busy", busy, 1);
    tick(); tick();
    chk("midreset_hold_busy", busy, 1);
    reset = 1'b0;
    count_busy(n);
    chk("midreset_len", n, 16);

    // Same-cycle write/read of r9.
    we3 = 1'b1; wa3 = 4'd9; wd3 = 8'h11;
    tick();
    wd3 = 8'h3C; ra1 = 4'd9;
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass_same_cycle", rd1, 8'h3C);
`else
    chk("nobypass_same_cycle", rd1, 8'h11);
`endif
    tick();
    we3 = 1'b0;
    #1;
    chk("r9_next_cycle", rd1, 8'h3C);

    // r0 stays zero even with a matching write in progress.
    we3 = 1'b1; wa3 = 4'd0; wd3 = 8'h5A; ra2 = 4'd0;
    #1;
    chk("r0_same_cycle", rd2, 0);
    tick();
    we3 = 1'b0;
    #1;
    chk("r0_after", rd2, 0);
    chk("r0_no_drop", wr_drop, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
